// File: rtl/wb_port_arbiter_if.sv
// Write-back arbiter bus: FU result handshake in, two register-file write lanes out.
// Optional macro WB_ARB_STATS_EN adds the stall_cnt statistics signal.
interface wb_port_arbiter_if #(
    parameter int NUM_FU = 4,
    parameter int XLEN   = 64
);
    logic [NUM_FU-1:0]      fu_valid;
    logic [NUM_FU-1:0]      fu_ready;
    logic [NUM_FU*5-1:0]    fu_rd;
    logic [NUM_FU*XLEN-1:0] fu_data;
    logic                   wb_hold;
    logic                   wb_reg_write0;
    logic [4:0]             wb_rd0;
    logic [XLEN-1:0]        wb_data0;
    logic                   wb_reg_write1;
    logic [4:0]             wb_rd1;
    logic [XLEN-1:0]        wb_data1;
`ifdef WB_ARB_STATS_EN
    logic [31:0]            stall_cnt;

    modport slave (
        input  fu_valid, fu_rd, fu_data, wb_hold,
        output fu_ready, wb_reg_write0, wb_rd0, wb_data0,
               wb_reg_write1, wb_rd1, wb_data1, stall_cnt
    );
    modport master (
        output fu_valid, fu_rd, fu_data, wb_hold,
        input  fu_ready, wb_reg_write0, wb_rd0, wb_data0,
               wb_reg_write1, wb_rd1, wb_data1, stall_cnt
    );
`else
    modport slave (
        input  fu_valid, fu_rd, fu_data, wb_hold,
        output fu_ready, wb_reg_write0, wb_rd0, wb_data0,
               wb_reg_write1, wb_rd1, wb_data1
    );
    modport master (
        output fu_valid, fu_rd, fu_data, wb_hold,
        input  fu_ready, wb_reg_write0, wb_rd0, wb_data0,
               wb_reg_write1, wb_rd1, wb_data1
    );
`endif
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing two register-file write lanes among NUM_FU result
// sources. Up to two grants per cycle, never two writes to the same nonzero rd.
// Optional macro WB_ARB_STATS_EN adds a 32-bit stall counter (bus.stall_cnt).
module wb_port_arbiter #(
    parameter int NUM_FU = 4,
    parameter int XLEN   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_port_arbiter_if.slave   bus
);
    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [4:0]        rd_a   [NUM_FU];
    logic [XLEN-1:0]   data_a [NUM_FU];
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_FU-1:0] grant;
    logic              s0_vld, s1_vld;
    logic [PW-1:0]     s0_idx, s1_idx;

    logic              we0_q, we1_q;
    logic [4:0]        rd0_q, rd1_q;
    logic [XLEN-1:0]   data0_q, data1_q;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
        return (x == PW'(NUM_FU - 1)) ? '0 : x + PW'(1);
    endfunction

    // Unpack the flat per-FU rd/data buses.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            rd_a[i]   = bus.fu_rd[5*i +: 5];
            data_a[i] = bus.fu_data[XLEN*i +: XLEN];
        end
    end

    // Scan from rr_ptr: first valid FU takes slot 0, first later non-colliding one slot 1.
    // Colliding FUs are skipped rather than ending the scan; rd 0 never collides.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        s0_vld = 1'b0;
        s1_vld = 1'b0;
        s0_idx = '0;
        s1_idx = '0;
        grant  = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_FU))
                sum = sum - (PW+1)'(NUM_FU);
            idx = sum[PW-1:0];
            if (rst_n && !bus.wb_hold && bus.fu_valid[idx]) begin
                if (!s0_vld) begin
                    s0_vld     = 1'b1;
                    s0_idx     = idx;
                    grant[idx] = 1'b1;
                end else if (!s1_vld && (rd_a[idx] != rd_a[s0_idx] ||
                                         rd_a[idx] == 5'd0 || rd_a[s0_idx] == 5'd0)) begin
                    s1_vld     = 1'b1;
                    s1_idx     = idx;
                    grant[idx] = 1'b1;
                end
            end
        end
    end

    assign bus.fu_ready = grant;

    // Pointer moves just past the last FU granted; slot 1 is always later in scan order.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (s1_vld)      rr_ptr_d = wrap_inc(s1_idx);
        else if (s0_vld) rr_ptr_d = wrap_inc(s0_idx);
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    // Registered write lanes: enables follow the grant, rd/data hold when a slot is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we0_q   <= 1'b0;
            rd0_q   <= '0;
            data0_q <= '0;
            we1_q   <= 1'b0;
            rd1_q   <= '0;
            data1_q <= '0;
        end else begin
            we0_q <= s0_vld && (rd_a[s0_idx] != 5'd0);
            we1_q <= s1_vld && (rd_a[s1_idx] != 5'd0);
            if (s0_vld) begin
                rd0_q   <= rd_a[s0_idx];
                data0_q <= data_a[s0_idx];
            end
            if (s1_vld) begin
                rd1_q   <= rd_a[s1_idx];
                data1_q <= data_a[s1_idx];
            end
        end
    end

    assign bus.wb_reg_write0 = we0_q;
    assign bus.wb_rd0        = rd0_q;
    assign bus.wb_data0      = data0_q;
    assign bus.wb_reg_write1 = we1_q;
    assign bus.wb_rd1        = rd1_q;
    assign bus.wb_data1      = data1_q;

`ifdef WB_ARB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count un-held cycles in which some valid FU was left waiting.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!bus.wb_hold && |(bus.fu_valid & ~grant))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Stall counter register, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized + directed bench for wb_port_arbiter (NUM_FU=4) with a queue-based reference model.
module tb_wb_port_arbiter;
    localparam int N = 4;
    localparam int XL = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.NUM_FU(N), .XLEN(XL)) bus ();
    wb_port_arbiter #(.NUM_FU(N), .XLEN(XL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // FU-side pending results
    logic          pv [N];
    logic [4:0]    prd[N];
    logic [XL-1:0] pd [N];
    logic          hold = 1'b0;
    bit            rand_en = 1'b0;

    // reference model state
    int            m_rr;
    logic          e_we0, e_we1;
    logic [4:0]    e_rd0, e_rd1;
    logic [XL-1:0] e_d0, e_d1;
    int            ga, gb;
    logic [N-1:0]  mg;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.fu_valid[i]          = pv[i];
            bus.fu_rd[5*i +: 5]      = prd[i];
            bus.fu_data[XL*i +: XL]  = pd[i];
        end
        bus.wb_hold = hold;
    endtask

    // Reference selection: candidates in round-robin order, first takes slot 0,
    // first later one without a nonzero-rd clash takes slot 1.
    task automatic model_select();
        int q[$];
        ga = -1; gb = -1; mg = '0;
        if (hold) return;
        for (int k = 0; k < N; k++)
            if (pv[(m_rr + k) % N]) q.push_back((m_rr + k) % N);
        if (q.size() == 0) return;
        ga = q[0];
        mg[ga] = 1'b1;
        for (int j = 1; j < q.size(); j++) begin
            if (prd[q[j]] != prd[ga] || prd[q[j]] == 0 || prd[ga] == 0) begin
                gb = q[j];
                mg[gb] = 1'b1;
                break;
            end
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        e_we0 = 0; e_rd0 = 0; e_d0 = 0;
        e_we1 = 0; e_rd1 = 0; e_d1 = 0;
    endtask

    // Called at negedge: compare against model, advance through posedge, refresh inputs.
    task automatic step();
        model_select();
        chk("ready", bus.fu_ready, mg);
        chk("we0", bus.wb_reg_write0, e_we0);
        chk("we1", bus.wb_reg_write1, e_we1);
        if (e_we0) begin chk("rd0", bus.wb_rd0, e_rd0); chk("d0", bus.wb_data0, e_d0); end
        if (e_we1) begin chk("rd1", bus.wb_rd1, e_rd1); chk("d1", bus.wb_data1, e_d1); end
        chk("no_dup_rd", bus.wb_reg_write0 && bus.wb_reg_write1 && bus.wb_rd0 == bus.wb_rd1, 0);
        @(posedge clk);
        e_we0 = 0; e_we1 = 0;
        if (ga >= 0) begin e_we0 = prd[ga] != 0; e_rd0 = prd[ga]; e_d0 = pd[ga]; end
        if (gb >= 0) begin e_we1 = prd[gb] != 0; e_rd1 = prd[gb]; e_d1 = pd[gb]; end
        if (gb >= 0)      m_rr = (gb + 1) % N;
        else if (ga >= 0) m_rr = (ga + 1) % N;
        if (ga >= 0) pv[ga] = 0;
        if (gb >= 0) pv[gb] = 0;
        #1;
        if (rand_en) begin
            for (int i = 0; i < N; i++)
                if (!pv[i] && ($urandom % 2 == 0)) begin
                    pv[i] = 1; prd[i] = 5'($urandom % 8); pd[i] = {$urandom, $urandom};
                end
            hold = ($urandom % 5 == 0);
        end
        drive();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin pv[i] = 1; prd[i] = 5'(i + 1); pd[i] = 64'(i); end
        hold = 0;
        drive();
        rst_n = 0;
        @(negedge clk);
        chk("rst_ready", bus.fu_ready, 0);
        chk("rst_we0", bus.wb_reg_write0, 0);
        chk("rst_we1", bus.wb_reg_write1, 0);
        chk("rst_rd0", bus.wb_rd0, 0);
        chk("rst_d1", bus.wb_data1, 0);
        for (int i = 0; i < N; i++) pv[i] = 0;
        drive();
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin pv[i] = 0; prd[i] = 0; pd[i] = 0; end
        drive();
        model_reset();

        // Test 1 + 2: two distinct rds granted together.
        do_reset();
        pv[0] = 1; prd[0] = 3; pd[0] = 64'hA;
        pv[2] = 1; prd[2] = 7; pd[2] = 64'hB;
        drive();
        @(negedge clk); chk("t2_ready", bus.fu_ready, 4'b0101); step();
        @(negedge clk);
        chk("t2_we0", bus.wb_reg_write0, 1); chk("t2_rd0", bus.wb_rd0, 3); chk("t2_d0", bus.wb_data0, 64'hA);
        chk("t2_we1", bus.wb_reg_write1, 1); chk("t2_rd1", bus.wb_rd1, 7); chk("t2_d1", bus.wb_data1, 64'hB);
        step();

        // Test 3: same nonzero rd -> serialized.
        do_reset();
        pv[0] = 1; prd[0] = 5; pd[0] = 64'h50;
        pv[1] = 1; prd[1] = 5; pd[1] = 64'h51;
        drive();
        @(negedge clk); chk("t3_ready_a", bus.fu_ready, 4'b0001); step();
        @(negedge clk);
        chk("t3_ready_b", bus.fu_ready, 4'b0010);
        chk("t3_we0", bus.wb_reg_write0, 1); chk("t3_rd0", bus.wb_rd0, 5); chk("t3_we1", bus.wb_reg_write1, 0);
        step();
        @(negedge clk); chk("t3_d0b", bus.wb_data0, 64'h51); step();

        // Test 4: all valid, distinct rd -> pairs alternate.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N; i++) begin pv[i] = 1; prd[i] = 5'(i + 10); pd[i] = 64'(c * 16 + i); end
            drive();
            @(negedge clk);
            chk("t4_ready", bus.fu_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            step();
        end

        // Test 5: rd 0 consumes a slot, writes nothing.
        do_reset();
        pv[1] = 1; prd[1] = 0; pd[1] = 64'h77;
        drive();
        @(negedge clk); chk("t5_ready", bus.fu_ready, 4'b0010); step();
        @(negedge clk); chk("t5_we0", bus.wb_reg_write0, 0); chk("t5_we1", bus.wb_reg_write1, 0); step();

        // Test 6: hold, then async reset right after a grant.
        do_reset();
        for (int i = 0; i < N; i++) begin pv[i] = 1; prd[i] = 5'(i + 20); pd[i] = 64'(i + 100); end
        hold = 1;
        drive();
        @(negedge clk); chk("t6_hold_ready", bus.fu_ready, 0); step();
        hold = 0;
        drive();
        @(negedge clk);
        chk("t6_hold_we0", bus.wb_reg_write0, 0);
        chk("t6_ready_rr", bus.fu_ready, 4'b0011);
        step();
        chk("t6_we0_pre", bus.wb_reg_write0, 1);
        rst_n = 0;
        #1;
        chk("t6_async_we0", bus.wb_reg_write0, 0);
        chk("t6_async_we1", bus.wb_reg_write1, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk); chk("t6_left_ready", bus.fu_ready, 4'b1100); step();

        // Randomized phase.
        rand_en = 1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
